// File: rtl/i_type_issue.sv
// Issue/writeback controller for the I-type execute unit: decodes OP-IMM words, reads rs1 from
// an internal 32x32 register file, drives the execute unit and writes its result back to rd.
module i_type_issue #(
    parameter int EX_LATENCY = 1,
    parameter int XLEN       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr_data,
    output logic [XLEN-1:0] ex_idata,
    output logic [XLEN-1:0] ex_rv1,
    output logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_result,
    output logic            rf_wr_en,
    output logic [4:0]      rf_wr_addr,
    output logic [XLEN-1:0] rf_wr_data,
    output logic            illegal,
    output logic [31:0]     retired,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    output logic [1:0]      dbg_state
);

    localparam int CW = (EX_LATENCY > 1) ? $clog2(EX_LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_ready;
    logic            r_illegal;
    logic            r_wr_en;
    logic [31:0]     r_retired;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_rv1;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_wb_data;
    logic [CW-1:0]   r_ex_cnt;
    logic [XLEN-1:0] r_rf [0:31];

    logic            w_legal;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rd;

    // Legality is judged on the incoming word so the illegal pulse lands in the DECODE cycle.
    assign w_funct3 = instr_data[14:12];
    assign w_funct7 = instr_data[31:25];
    assign w_legal  = (instr_data[6:0] == 7'b0010011)
                    && !((w_funct3 == 3'b001) && (w_funct7 != 7'b0000000))
                    && !((w_funct3 == 3'b101) && (w_funct7 != 7'b0000000)
                                              && (w_funct7 != 7'b0100000));

    assign w_rs1 = r_instr[19:15];
    assign w_rd  = r_instr[11:7];

    // Handshake: a word transfers on a rising edge where instr_valid && instr_ready; ready is
    // only high in IDLE, so the source must hold its word stable until that edge.
    assign instr_ready = r_ready;
    assign illegal     = r_illegal;
    assign retired     = r_retired;
    assign ex_idata    = r_instr;
    assign ex_rv1      = r_rv1;
    assign ex_imm      = r_imm;
    assign rf_wr_en    = r_wr_en;
    assign rf_wr_addr  = w_rd;
    assign rf_wr_data  = r_wb_data;
    assign dbg_data    = (dbg_addr == 5'd0) ? '0 : r_rf[dbg_addr];
    assign dbg_state   = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_illegal <= 1'b0;
            r_wr_en   <= 1'b0;
            r_retired <= '0;
            r_instr   <= '0;
            r_rv1     <= '0;
            r_imm     <= '0;
            r_wb_data <= '0;
            r_ex_cnt  <= '0;
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            r_illegal <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_instr   <= instr_data;
                        r_illegal <= !w_legal;
                        r_ready   <= 1'b0;
                        r_state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (r_illegal) begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_rv1    <= (w_rs1 == 5'd0) ? '0 : r_rf[w_rs1];
                        r_imm    <= {{20{r_instr[31]}}, r_instr[31:20]};
                        r_ex_cnt <= '0;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_ex_cnt == CW'(EX_LATENCY - 1)) begin
                        r_wb_data <= ex_result;
                        r_wr_en   <= 1'b1;
                        r_state   <= S_WB;
                    end else begin
                        r_ex_cnt <= r_ex_cnt + 1'b1;
                    end
                end
                S_WB: begin
                    if (w_rd != 5'd0) begin
                        r_rf[w_rd] <= r_wb_data;
                    end
                    r_retired <= r_retired + 32'd1;
                    r_wr_en   <= 1'b0;
                    r_ready   <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i_type_issue.sv
// Bench for i_type_issue: directed cases plus random OP-IMM traffic against a register-file model.
module tb_i_type_issue;

    logic        clk = 1'b0;
    logic        rst, instr_valid;
    logic [31:0] instr_data;
    logic        instr_ready, rf_wr_en, illegal;
    logic [31:0] ex_idata, ex_rv1, ex_imm, ex_result, rf_wr_data, retired, dbg_data;
    logic [4:0]  rf_wr_addr, dbg_addr;
    logic [1:0]  dbg_state;

    logic        rst3, instr_valid3;
    logic [31:0] instr_data3;
    logic        instr_ready3, rf_wr_en3, illegal3;
    logic [31:0] ex_idata3, ex_rv13, ex_imm3, ex_result3, rf_wr_data3, retired3, dbg_data3;
    logic [4:0]  rf_wr_addr3, dbg_addr3;
    logic [1:0]  dbg_state3;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] mrf [0:31];
    logic [31:0] m_retired;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    // Execute unit stand-in: RV32I OP-IMM arithmetic.
    function automatic logic [31:0] alu(input logic [2:0] f3, input logic b30,
                                        input logic [31:0] a, input logic [31:0] imm);
        case (f3)
            3'd0: return a + imm;
            3'd1: return a << imm[4:0];
            3'd2: return ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            3'd3: return (a < imm) ? 32'd1 : 32'd0;
            3'd4: return a ^ imm;
            3'd5: return b30 ? $unsigned($signed(a) >>> imm[4:0]) : (a >> imm[4:0]);
            3'd6: return a | imm;
            default: return a & imm;
        endcase
    endfunction

    function automatic logic legal(input logic [31:0] w);
        if (w[6:0] != 7'h13) return 1'b0;
        if (w[14:12] == 3'd1) return w[31:25] == 7'h00;
        if (w[14:12] == 3'd5) return (w[31:25] == 7'h00) || (w[31:25] == 7'h20);
        return 1'b1;
    endfunction

    function automatic logic [31:0] sext(input logic [31:0] w);
        return {{20{w[31]}}, w[31:20]};
    endfunction

    assign ex_result  = alu(ex_idata[14:12], ex_idata[30], ex_rv1, ex_imm);
    assign ex_result3 = alu(ex_idata3[14:12], ex_idata3[30], ex_rv13, ex_imm3);

    i_type_issue #(.EX_LATENCY(1), .XLEN(32)) u_dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .ex_idata(ex_idata), .ex_rv1(ex_rv1), .ex_imm(ex_imm),
        .ex_result(ex_result), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
        .rf_wr_data(rf_wr_data), .illegal(illegal), .retired(retired),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
    );

    i_type_issue #(.EX_LATENCY(3), .XLEN(32)) u_dut3 (
        .clk(clk), .rst(rst3), .instr_valid(instr_valid3), .instr_ready(instr_ready3),
        .instr_data(instr_data3), .ex_idata(ex_idata3), .ex_rv1(ex_rv13), .ex_imm(ex_imm3),
        .ex_result(ex_result3), .rf_wr_en(rf_wr_en3), .rf_wr_addr(rf_wr_addr3),
        .rf_wr_data(rf_wr_data3), .illegal(illegal3), .retired(retired3),
        .dbg_addr(dbg_addr3), .dbg_data(dbg_data3), .dbg_state(dbg_state3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Follows one word from the handshake edge (called #1 after it) to the next IDLE cycle.
    task automatic flow(input logic [31:0] w);
        logic        lg;
        logic [4:0]  rd;
        logic [31:0] val;
        lg = legal(w);
        rd = w[11:7];
        @(negedge clk);
        check("dec_illegal", illegal, !lg);
        check("dec_ready", instr_ready, 1'b0);
        if (!lg) begin
            @(negedge clk);
            check("ill_ready", instr_ready, 1'b1);
            check("ill_pulse_end", illegal, 1'b0);
            check("ill_no_wr", rf_wr_en, 1'b0);
            check("ill_retired", retired, m_retired);
            return;
        end
        exp_q.push_back(alu(w[14:12], w[30], mrf[w[19:15]], sext(w)));
        @(negedge clk);
        check("ex_idata", ex_idata, w);
        check("ex_rv1", ex_rv1, mrf[w[19:15]]);
        check("ex_imm", ex_imm, sext(w));
        check("ex_no_wr", rf_wr_en, 1'b0);
        check("ex_ready", instr_ready, 1'b0);
        @(negedge clk);
        val = exp_q.pop_front();
        check("wb_en", rf_wr_en, 1'b1);
        check("wb_addr", rf_wr_addr, rd);
        check("wb_data", rf_wr_data, val);
        check("wb_ready", instr_ready, 1'b0);
        if (rd != 5'd0) mrf[rd] = val;
        m_retired = m_retired + 32'd1;
        @(negedge clk);
        check("idle_ready", instr_ready, 1'b1);
        check("idle_no_wr", rf_wr_en, 1'b0);
        check("retired", retired, m_retired);
        dbg_addr = rd;
        #1;
        check("rd_readback", dbg_data, mrf[rd]);
    endtask

    task automatic issue(input logic [31:0] w);
        int n;
        n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("ready_timeout", instr_ready, 1'b1);
        instr_valid = 1'b1;
        instr_data  = w;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        flow(w);
    endtask

    initial begin
        logic [31:0] w;
        logic [6:0]  top;
        for (int i = 0; i < 32; i++) mrf[i] = '0;
        m_retired    = '0;
        rst          = 1'b1;
        rst3         = 1'b1;
        instr_valid  = 1'b0;
        instr_valid3 = 1'b0;
        instr_data   = '0;
        instr_data3  = '0;
        dbg_addr     = '0;
        dbg_addr3    = '0;

        // Reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rst3 = 1'b0;
        @(negedge clk);
        check("rst_ready", instr_ready, 1'b1);
        check("rst_retired", retired, 32'd0);
        check("rst_wr_en", rf_wr_en, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        check("rst_ex_idata", ex_idata, 32'd0);
        check("rst_ex_rv1", ex_rv1, 32'd0);
        check("rst_ex_imm", ex_imm, 32'd0);
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a);
            #1;
            check("rst_dbg", dbg_data, 32'd0);
        end

        // ADDI chain, x0 target, illegal words
        issue(32'h00500093);
        issue(32'hFFF08113);
        check("chain_x1", mrf[1], 32'd5);
        check("chain_x2", mrf[2], 32'd4);
        check("chain_retired", m_retired, 32'd2);
        issue(32'h00700013);
        dbg_addr = 5'd0;
        #1 check("x0_zero", dbg_data, 32'd0);
        issue(32'h00000033);
        issue(32'h02109093);

        // Backpressure: valid stays high, second word must wait for IDLE
        instr_valid = 1'b1;
        instr_data  = 32'hFF800213;
        @(posedge clk);
        #1 instr_data = 32'h4020D193;
        flow(32'hFF800213);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        flow(32'h4020D193);
        check("srai_imm", sext(32'h4020D193), 32'h00000402);

        // Random OP-IMM traffic
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                w = $urandom;
            end else begin
                w = $urandom;
                w[6:0] = 7'h13;
                if (w[14:12] == 3'd1 || w[14:12] == 3'd5) begin
                    case ($urandom_range(0, 3))
                        0: top = 7'h00;
                        1: top = 7'h20;
                        2: top = 7'($urandom);
                        default: top = 7'h00;
                    endcase
                    w[31:25] = top;
                end
            end
            issue(w);
        end
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a);
            #1;
            check("final_rf", dbg_data, mrf[a]);
        end

        // EX_LATENCY=3: normal retire, then reset in the 2nd EXEC cycle
        @(negedge clk);
        instr_valid3 = 1'b1;
        instr_data3  = 32'h00300093;
        @(posedge clk);
        #1 instr_valid3 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("l3_no_wr_early", rf_wr_en3, 1'b0);
        end
        @(negedge clk);
        check("l3_wb_en", rf_wr_en3, 1'b1);
        check("l3_wb_data", rf_wr_data3, 32'd3);
        @(negedge clk);
        check("l3_ready", instr_ready3, 1'b1);
        check("l3_retired", retired3, 32'd1);
        instr_valid3 = 1'b1;
        instr_data3  = 32'h00900293;
        @(posedge clk);
        #1 instr_valid3 = 1'b0;
        repeat (3) @(negedge clk);
        rst3 = 1'b1;
        @(posedge clk);
        #1 rst3 = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", instr_ready3, 1'b1);
        for (int c = 0; c < 4; c++) begin
            check("mid_rst_no_wr", rf_wr_en3, 1'b0);
            check("mid_rst_retired", retired3, 32'd0);
            @(negedge clk);
        end
        dbg_addr3 = 5'd5;
        #1 check("mid_rst_x5", dbg_data3, 32'd0);
        dbg_addr3 = 5'd1;
        #1 check("mid_rst_x1", dbg_data3, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
